colour_frame_scheduler: RTL and testbench
=========================================

Name: colour_frame_scheduler

Overview:
- Sits directly upstream of the final colour stage in the VGA pixel path.
- Arbitrates between N_LAYERS sprite/graphics requesters (player, aliens, shots, shields) for each pixel and applies off-screen forcing.
- Latches per-frame layer collisions.
- Schedules the game-logic update window so that sprite state only changes during vertical blanking.

Parameters:
- N_LAYERS, 4, number of colour requesters; layer 0 has the highest priority.
- SCREEN_WIDTH, 640, visible columns.
- SCREEN_HEIGHT, 480, visible lines.
- BG_COLOR, 3'b000, colour when no layer hits.
- OFF_COLOR, 3'b111, colour outside the visible area.

Ports:
- clk  in  1  system clock.
- rst  in  1  asynchronous, active-high reset.
- hPos  in  10  current column from the sync generator.
- vPos  in  10  current line from the sync generator.
- layer_hit  in  N_LAYERS  bit i set when layer i covers (hPos, vPos).
- layer_color  in  3*N_LAYERS  colour of layer i in bits [3i+2:3i].
- upd_req  in  1  game logic requests an update window (level).
- upd_done  in  1  game logic finished its update (1-cycle pulse).
- upd_grant  out  1  update window open.
- upd_overrun  out  1  1-cycle pulse: window closed by frame start before upd_done.
- frame_start  out  1  1-cycle pulse on entry to (0,0).
- coll_flags  out  N_LAYERS  per-layer collision flags of the previous frame.
- color  out  3  pixel colour to the final colour stage.

Behaviour:
- Reset: color=OFF_COLOR; upd_grant=0; upd_overrun=0; frame_start=0; coll_flags=0; all pipeline and internal registers cleared; FSM in S_ACTIVE.
- Pixel pipeline, latency 2 clocks from inputs to color:
  - Stage 1 registers hPos, vPos, layer_hit, layer_color.
  - Stage 2 computes the output:
    - If hPos>=SCREEN_WIDTH or vPos>=SCREEN_HEIGHT, color=OFF_COLOR.
    - Otherwise, if any hit, color is the colour of the lowest-index hit layer.
    - Otherwise, color=BG_COLOR.
- Events, edge-detected on raw inputs against a registered previous value, so they fire once even when the pixel enable is slower than clk:
  - ev_vblank when (vPos==SCREEN_HEIGHT && hPos==0) becomes true.
  - ev_frame when (vPos==0 && hPos==0) becomes true.
  - frame_start = registered ev_frame, 1 cycle.
- Collision:
  - Working register coll_acc.
  - At stage 1, in the visible area, if popcount(layer_hit)>=2, OR layer_hit into coll_acc.
  - On ev_frame: coll_flags<=coll_acc and coll_acc<=0 in the same cycle. A hit in that same cycle goes into the new coll_acc.
- Update FSM:
  - S_ACTIVE: upd_grant=0. On ev_vblank: go to S_GRANT if upd_req=1, else to S_VBLANK.
  - S_VBLANK: if upd_req=1, go to S_GRANT next cycle. On ev_frame, go to S_ACTIVE (ev_frame wins over upd_req in the same cycle).
  - S_GRANT: upd_grant=1.
    - On upd_done, go to S_VBLANK. A second request in the same vblank is allowed.
    - On ev_frame without upd_done, pulse upd_overrun and go to S_ACTIVE.
    - upd_done and ev_frame in the same cycle count as done: no overrun.
  - upd_done outside S_GRANT is ignored.
  - upd_grant is registered: asserted the cycle after entry to S_GRANT, deasserted the cycle after exit.
- Widths: hPos/vPos compare as 10-bit unsigned. Coordinates 1023 are treated as off-screen.
- Reset mid-frame or mid-grant: asynchronous clear of all state; no overrun pulse is generated.

Decomposition:
- Shared package holds:
  - SCREEN_WIDTH, SCREEN_HEIGHT, OFF_COLOR, BG_COLOR.
  - The 3-bit colour typedef.
  - The FSM state enum {S_ACTIVE, S_VBLANK, S_GRANT}.
- One natural sub-module, layer_priority_mux: a combinational lowest-index-wins selector with an any_hit output, reused by the stage-2 colour select.

Test Plan:
- Reset mid-frame with layer_hit=4'b0110 → color=3'b111, coll_flags=0, upd_grant=0 immediately. After release at (10,10) with layer1 colour 3'b010, color=3'b010 exactly 2 clocks later.
- Priority and blanking:
  - hPos=100, vPos=50, hits 4'b1010 with layer1=3'b100, layer3=3'b001 → color=3'b100 after 2 clocks.
  - hPos=640 → 3'b111.
  - No hits → 3'b000.
- Collision: during frame k, a single pixel with hits 4'b0011 → at the next ev_frame coll_flags=4'b0011. A frame with no overlap → coll_flags=4'b0000 at the following ev_frame.
- Grant handshake: upd_req held high from line 300 → upd_grant rises 2 clocks after vPos reaches 480 at hPos 0. upd_done at line 500 → grant falls next cycle, no overrun.
- Overrun: grant open and no upd_done → at vPos=0,hPos=0, upd_overrun pulses exactly 1 cycle, grant drops, frame_start pulses.
- Slow pixel enable: hPos/vPos held at (0,480) for 2 clocks → ev_vblank, frame_start and grant entry each occur once only.

Source files
------------

// File: rtl/colour_frame_scheduler_pkg.sv
// Shared screen geometry, colour type and update-window FSM states for the frame scheduler.
// Latency: n/a (declarations and one pure helper function).
// Backpressure: n/a.
package colour_frame_scheduler_pkg;

  localparam logic [9:0] SCREEN_WIDTH  = 10'd640;
  localparam logic [9:0] SCREEN_HEIGHT = 10'd480;

  typedef logic [2:0] colour_t;

  localparam colour_t BG_COLOR  = 3'b000;
  localparam colour_t OFF_COLOR = 3'b111;

  typedef enum logic [1:0] {
    S_ACTIVE = 2'd0,
    S_VBLANK = 2'd1,
    S_GRANT  = 2'd2
  } upd_state_t;

  // Unsigned compare, so the 1023 "parked" coordinate counts as off-screen.
  function automatic logic on_screen(input logic [9:0] h, input logic [9:0] v);
    return (h < SCREEN_WIDTH) && (v < SCREEN_HEIGHT);
  endfunction

endpackage

// File: rtl/colour_frame_scheduler_if.sv
// Bundles pixel-position, layer, game-update handshake and colour-out signals of the scheduler.
// Latency: n/a (wiring only).
// Backpressure: none; the pixel path is free-running and the update window is a level/pulse handshake.
interface colour_frame_scheduler_if #(parameter int N_LAYERS = 4);
  import colour_frame_scheduler_pkg::*;

  logic [9:0]            hPos;
  logic [9:0]            vPos;
  logic [N_LAYERS-1:0]   layer_hit;
  logic [3*N_LAYERS-1:0] layer_color;
  logic                  upd_req;
  logic                  upd_done;
  logic                  upd_grant;
  logic                  upd_overrun;
  logic                  frame_start;
  logic [N_LAYERS-1:0]   coll_flags;
  colour_t               color;

  // Master: sync generator, sprite layers and game logic feeding the scheduler.
  modport master (
    output hPos, vPos, layer_hit, layer_color, upd_req, upd_done,
    input  upd_grant, upd_overrun, frame_start, coll_flags, color
  );

  // Slave: the scheduler itself.
  modport slave (
    input  hPos, vPos, layer_hit, layer_color, upd_req, upd_done,
    output upd_grant, upd_overrun, frame_start, coll_flags, color
  );

endinterface

// File: rtl/colour_frame_scheduler_layer_priority_mux.sv
// Lowest-index-wins colour selector across the sprite layers, with an any-hit flag.
// Latency: combinational.
// Backpressure: none.
module layer_priority_mux
  import colour_frame_scheduler_pkg::*;
#(
  parameter int N_LAYERS = 4
) (
  input  logic [N_LAYERS-1:0]   hit,
  input  logic [3*N_LAYERS-1:0] colors,
  output colour_t               sel_color,
  output logic                  any_hit
);

  // Walk from the lowest priority upward so the lowest-index hit overwrites last.
  always_comb begin
    sel_color = BG_COLOR;
    any_hit   = |hit;
    for (int i = N_LAYERS - 1; i >= 0; i--) begin
      if (hit[i]) begin
        sel_color = colors[3*i +: 3];
      end
    end
  end

endmodule

// File: rtl/colour_frame_scheduler.sv
// Per-pixel layer arbitration with off-screen forcing, per-frame collision latch, vblank update window.
// Latency: 2 clocks hPos/vPos/layer inputs to color; events act on the clock edge that first sees them.
// Backpressure: none; upd_grant is a registered window, closed with upd_overrun if the frame restarts first.
module colour_frame_scheduler
  import colour_frame_scheduler_pkg::*;
#(
  parameter int N_LAYERS = 4
) (
  input logic                     clk,
  input logic                     rst,
  colour_frame_scheduler_if.slave bus
);

  logic [9:0]            s1_h;
  logic [9:0]            s1_v;
  logic [N_LAYERS-1:0]   s1_hit;
  logic [3*N_LAYERS-1:0] s1_col;

  colour_t mux_color;
  logic    mux_any;
  colour_t color_q;

  logic vblank_now;
  logic frame_now;
  logic vblank_prev;
  logic frame_prev;
  logic ev_vblank;
  logic ev_frame;
  logic frame_start_q;

  logic                collide;
  logic [N_LAYERS-1:0] coll_acc;
  logic [N_LAYERS-1:0] coll_q;

  upd_state_t state;
  upd_state_t state_nxt;
  logic       overrun_nxt;
  logic       grant_q;
  logic       overrun_q;

  // Event conditions are taken from the raw position so that a slow pixel enable,
  // which holds one coordinate for several clocks, still yields a single-cycle event.
  assign vblank_now = (bus.vPos == SCREEN_HEIGHT) && (bus.hPos == 10'd0);
  assign frame_now  = (bus.vPos == 10'd0) && (bus.hPos == 10'd0);
  assign ev_vblank  = vblank_now && !vblank_prev;
  assign ev_frame   = frame_now && !frame_prev;

  // Only visible pixels covered by two or more layers count as a collision.
  assign collide = on_screen(bus.hPos, bus.vPos) && ($countones(bus.layer_hit) >= 2);

  layer_priority_mux #(
    .N_LAYERS (N_LAYERS)
  ) u_prio (
    .hit       (s1_hit),
    .colors    (s1_col),
    .sel_color (mux_color),
    .any_hit   (mux_any)
  );

  // Stage 1: capture the pixel position and layer requests.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      s1_h   <= '0;
      s1_v   <= '0;
      s1_hit <= '0;
      s1_col <= '0;
    end else begin
      s1_h   <= bus.hPos;
      s1_v   <= bus.vPos;
      s1_hit <= bus.layer_hit;
      s1_col <= bus.layer_color;
    end
  end

  // Stage 2: off-screen forcing beats layer priority, which beats background.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      color_q <= OFF_COLOR;
    end else if (!on_screen(s1_h, s1_v)) begin
      color_q <= OFF_COLOR;
    end else if (mux_any) begin
      color_q <= mux_color;
    end else begin
      color_q <= BG_COLOR;
    end
  end

  // Edge-detect history for the vblank and frame positions, plus the frame_start pulse.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      vblank_prev   <= 1'b0;
      frame_prev    <= 1'b0;
      frame_start_q <= 1'b0;
    end else begin
      vblank_prev   <= vblank_now;
      frame_prev    <= frame_now;
      frame_start_q <= ev_frame;
    end
  end

  // Collision accumulator: publish and restart at frame start; a hit on that very pixel
  // belongs to the new frame.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      coll_acc <= '0;
      coll_q   <= '0;
    end else if (ev_frame) begin
      coll_q   <= coll_acc;
      coll_acc <= collide ? bus.layer_hit : '0;
    end else if (collide) begin
      coll_acc <= coll_acc | bus.layer_hit;
    end
  end

  // Update-window next state; a done coinciding with frame start is a clean finish.
  always_comb begin
    state_nxt   = state;
    overrun_nxt = 1'b0;
    case (state)
      S_ACTIVE: begin
        if (ev_vblank) begin
          if (bus.upd_req) begin
            state_nxt = S_GRANT;
          end else begin
            state_nxt = S_VBLANK;
          end
        end
      end
      S_VBLANK: begin
        if (ev_frame) begin
          state_nxt = S_ACTIVE;
        end else if (bus.upd_req) begin
          state_nxt = S_GRANT;
        end
      end
      S_GRANT: begin
        if (bus.upd_done) begin
          if (ev_frame) begin
            state_nxt = S_ACTIVE;
          end else begin
            state_nxt = S_VBLANK;
          end
        end else if (ev_frame) begin
          state_nxt   = S_ACTIVE;
          overrun_nxt = 1'b1;
        end
      end
      default: begin
        state_nxt = S_ACTIVE;
      end
    endcase
  end

  // Update-window state plus registered grant (one cycle behind the state) and overrun pulse.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state     <= S_ACTIVE;
      grant_q   <= 1'b0;
      overrun_q <= 1'b0;
    end else begin
      state     <= state_nxt;
      grant_q   <= (state == S_GRANT);
      overrun_q <= overrun_nxt;
    end
  end

  assign bus.color       = color_q;
  assign bus.frame_start = frame_start_q;
  assign bus.coll_flags  = coll_q;
  assign bus.upd_grant   = grant_q;
  assign bus.upd_overrun = overrun_q;

endmodule

// File: tb/tb_colour_frame_scheduler.sv
// Bench for colour_frame_scheduler: scoreboarded pixel colours plus directed event/handshake checks.
// Latency: expects color 2 clocks after each driven pixel.
// Backpressure: n/a.
module tb_colour_frame_scheduler;
  import colour_frame_scheduler_pkg::*;

  localparam int NL = 4;
  // Packed {layer3, layer2, layer1, layer0}
  localparam logic [11:0] LC_A = {3'b001, 3'b011, 3'b100, 3'b110};
  localparam logic [11:0] LC_B = {3'b001, 3'b011, 3'b010, 3'b110};

  logic clk = 1'b0;
  logic rst;
  logic [11:0] lc;
  int checks = 0;
  int errors = 0;
  colour_t exp_q[$];

  colour_frame_scheduler_if #(.N_LAYERS(NL)) bus();

  colour_frame_scheduler #(.N_LAYERS(NL)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  always #5 clk = ~clk;

  task automatic check_val(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got=%0h exp=%0h at %0t", tag, got, exp, $time);
    end
  endtask

  function automatic colour_t model_color(input logic [9:0] h, input logic [9:0] v,
                                          input logic [3:0] hit, input logic [11:0] cols);
    colour_t c;
    logic found;
    c = 3'b000;
    found = 1'b0;
    if (h >= 10'd640 || v >= 10'd480) begin
      c = 3'b111;
    end else begin
      for (int i = 0; i < NL; i++) begin
        if (hit[i] && !found) begin
          c = cols[3*i +: 3];
          found = 1'b1;
        end
      end
    end
    return c;
  endfunction

  task automatic tick();
    colour_t e;
    @(posedge clk);
    #1;
    if (exp_q.size() >= 2) begin
      e = exp_q.pop_front();
      check_val("color", bus.color, e);
    end
  endtask

  task automatic drive(input logic [9:0] h, input logic [9:0] v, input logic [3:0] hit);
    bus.hPos        = h;
    bus.vPos        = v;
    bus.layer_hit   = hit;
    bus.layer_color = lc;
    exp_q.push_back(model_color(h, v, hit, lc));
  endtask

  task automatic pix(input logic [9:0] h, input logic [9:0] v, input logic [3:0] hit);
    tick();
    bus.upd_done = 1'b0;
    drive(h, v, hit);
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog expired at %0t", $time);
    $fatal(1, "watchdog");
  end

  initial begin
    lc              = LC_A;
    rst             = 1'b1;
    bus.hPos        = 10'd700;
    bus.vPos        = 10'd500;
    bus.layer_hit   = '0;
    bus.layer_color = lc;
    bus.upd_req     = 1'b0;
    bus.upd_done    = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    check_val("rst_color", bus.color, 3'b111);
    check_val("rst_grant", bus.upd_grant, 1'b0);
    check_val("rst_overrun", bus.upd_overrun, 1'b0);
    check_val("rst_frame_start", bus.frame_start, 1'b0);
    check_val("rst_coll", bus.coll_flags, 4'b0000);
    rst = 1'b0;
    exp_q.delete();

    pix(10'd700, 10'd500, 4'b0000);
    pix(10'd700, 10'd500, 4'b0000);

    // Frame k0 begins
    pix(10'd0, 10'd0, 4'b0000);
    pix(10'd1, 10'd0, 4'b0000);
    check_val("fs_k0", bus.frame_start, 1'b1);
    check_val("coll_k0_start", bus.coll_flags, 4'b0000);
    pix(10'd2, 10'd0, 4'b0000);
    check_val("fs_k0_end", bus.frame_start, 1'b0);

    // Priority and blanking (colours checked by scoreboard)
    pix(10'd100, 10'd50, 4'b1010);
    pix(10'd640, 10'd50, 4'b1111);
    pix(10'd100, 10'd50, 4'b0000);
    pix(10'd101, 10'd50, 4'b1000);
    pix(10'd5, 10'd479, 4'b0100);
    pix(10'd639, 10'd1023, 4'b0001);
    pix(10'd1023, 10'd10, 4'b0001);
    pix(10'd639, 10'd479, 4'b0001);

    // Grant handshake with vblank position held two clocks
    bus.upd_req = 1'b1;
    pix(10'd0, 10'd300, 4'b0000);
    pix(10'd320, 10'd300, 4'b0000);
    pix(10'd0, 10'd480, 4'b0000);
    pix(10'd0, 10'd480, 4'b0000);
    check_val("grant_lag1", bus.upd_grant, 1'b0);
    pix(10'd1, 10'd480, 4'b0000);
    check_val("grant_rise", bus.upd_grant, 1'b1);
    pix(10'd0, 10'd500, 4'b0000);
    bus.upd_req  = 1'b0;
    bus.upd_done = 1'b1;
    pix(10'd1, 10'd500, 4'b0000);
    pix(10'd2, 10'd500, 4'b0000);
    check_val("grant_fall", bus.upd_grant, 1'b0);
    check_val("no_overrun_done", bus.upd_overrun, 1'b0);

    // Second request in the same vblank, then let the frame restart on it
    pix(10'd0, 10'd510, 4'b0000);
    bus.upd_req = 1'b1;
    pix(10'd1, 10'd510, 4'b0000);
    pix(10'd2, 10'd510, 4'b0000);
    check_val("grant_again", bus.upd_grant, 1'b1);
    bus.upd_req = 1'b0;
    pix(10'd799, 10'd524, 4'b0000);
    pix(10'd0, 10'd0, 4'b0000);
    pix(10'd0, 10'd0, 4'b0000);
    check_val("overrun_pulse", bus.upd_overrun, 1'b1);
    check_val("fs_k1", bus.frame_start, 1'b1);
    check_val("coll_k0", bus.coll_flags, 4'b1010);
    pix(10'd1, 10'd0, 4'b0000);
    check_val("overrun_once", bus.upd_overrun, 1'b0);
    check_val("fs_once", bus.frame_start, 1'b0);
    check_val("grant_drop", bus.upd_grant, 1'b0);

    // Frame k1: one overlapping pixel, stray done, request during vblank, done at frame start
    pix(10'd200, 10'd100, 4'b0011);
    pix(10'd300, 10'd100, 4'b0100);
    pix(10'd0, 10'd480, 4'b0000);
    pix(10'd1, 10'd480, 4'b0000);
    bus.upd_done = 1'b1;
    pix(10'd2, 10'd480, 4'b0000);
    pix(10'd3, 10'd480, 4'b0000);
    check_val("stray_done_grant", bus.upd_grant, 1'b0);
    check_val("stray_done_overrun", bus.upd_overrun, 1'b0);
    bus.upd_req = 1'b1;
    pix(10'd0, 10'd490, 4'b0000);
    pix(10'd1, 10'd490, 4'b0000);
    check_val("vblank_to_grant", bus.upd_grant, 1'b1);
    bus.upd_req = 1'b0;
    pix(10'd799, 10'd524, 4'b0000);
    pix(10'd0, 10'd0, 4'b0000);
    bus.upd_done = 1'b1;
    pix(10'd1, 10'd0, 4'b0000);
    check_val("done_at_frame_overrun", bus.upd_overrun, 1'b0);
    check_val("fs_k2", bus.frame_start, 1'b1);
    check_val("coll_k1", bus.coll_flags, 4'b0011);
    pix(10'd2, 10'd0, 4'b0000);
    check_val("done_at_frame_overrun2", bus.upd_overrun, 1'b0);
    check_val("done_at_frame_grant", bus.upd_grant, 1'b0);

    // Frame k2: single hits and off-screen overlaps only; open a grant then reset into it
    pix(10'd50, 10'd60, 4'b0001);
    pix(10'd51, 10'd60, 4'b1000);
    pix(10'd700, 10'd100, 4'b1111);
    pix(10'd60, 10'd1000, 4'b0011);
    bus.upd_req = 1'b1;
    pix(10'd0, 10'd480, 4'b0000);
    pix(10'd1, 10'd480, 4'b0000);
    pix(10'd2, 10'd480, 4'b0000);
    check_val("grant_pre_rst", bus.upd_grant, 1'b1);
    pix(10'd10, 10'd10, 4'b0110);

    rst = 1'b1;
    #1;
    check_val("midrst_color", bus.color, 3'b111);
    check_val("midrst_coll", bus.coll_flags, 4'b0000);
    check_val("midrst_grant", bus.upd_grant, 1'b0);
    check_val("midrst_overrun", bus.upd_overrun, 1'b0);
    exp_q.delete();
    bus.upd_req = 1'b0;
    lc = LC_B;
    drive(10'd10, 10'd10, 4'b0110);
    #1;
    rst = 1'b0;
    pix(10'd11, 10'd10, 4'b0000);
    check_val("post_rst_color_lag1", bus.color, 3'b000);
    check_val("post_rst_overrun", bus.upd_overrun, 1'b0);
    pix(10'd12, 10'd10, 4'b0000);
    check_val("post_rst_grant", bus.upd_grant, 1'b0);
    pix(10'd0, 10'd0, 4'b0000);
    pix(10'd1, 10'd0, 4'b0000);
    check_val("coll_post_rst", bus.coll_flags, 4'b0110);
    check_val("fs_post_rst", bus.frame_start, 1'b1);

    // Frame with no overlap at all
    pix(10'd70, 10'd70, 4'b0100);
    pix(10'd71, 10'd70, 4'b0010);
    pix(10'd0, 10'd480, 4'b0000);
    pix(10'd0, 10'd0, 4'b0000);
    pix(10'd1, 10'd0, 4'b0000);
    check_val("coll_no_overlap", bus.coll_flags, 4'b0000);
    tick();
    tick();

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
